ysyx_22041412_axi_rd_arb: RTL and testbench

//  Read-channel arbiter sharing the single AXI read master between I-cache refill and D-cache refill.

---
 rtl/ysyx_22041412_axi_rd_arb.sv | 148 ++++++++++++++
 tb/tb_ysyx_22041412_axi_rd_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_axi_rd_arb.sv
// Round-robin read-channel arbiter: I-cache and D-cache refills share one AXI read master.
// Optional AXI_RD_ARB_PERF_EN adds per-requester wait-cycle counters.
module ysyx_22041412_axi_rd_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] i_r_addr_i,
  input  logic [7:0]            i_r_len_i,
  output logic                  i_r_ready_o,
  output logic                  i_r_last_o,
  input  logic                  d_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] d_r_addr_i,
  input  logic [7:0]            d_r_len_i,
  output logic                  d_r_ready_o,
  output logic                  d_r_last_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  r_valid_o,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  output logic [7:0]            r_len_o,
  input  logic                  r_ready_i,
  input  logic                  r_last_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  err_o
`ifdef AXI_RD_ARB_PERF_EN
  ,
  output logic [63:0]           i_wait_cnt_o,
  output logic [63:0]           d_wait_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_e     state_r;
  logic       last_gnt_r;
  logic [7:0] beat_cnt_r;
  logic       beat_s;
  logic       last_beat_s;
  logic       pick_i_s;
  logic       pick_d_s;

  // Beat qualification and round-robin pick; beats seen while IDLE are ignored.
  always_comb begin
    beat_s      = (state_r != IDLE) && r_ready_i;
    last_beat_s = beat_s && r_last_i;
    pick_i_s    = i_r_valid_i && (!d_r_valid_i || (last_gnt_r == SIDE_D));
    pick_d_s    = d_r_valid_i && !pick_i_s;
  end

  // Grant FSM: latch the winner's burst, hold it until the last beat, then force one IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      r_valid_o  <= 1'b0;
      r_addr_o   <= {ADDR_WIDTH{1'b0}};
      r_len_o    <= 8'd0;
      err_o      <= 1'b0;
      beat_cnt_r <= 8'd0;
      last_gnt_r <= SIDE_I;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_i_s) begin
            state_r    <= GNT_I;
            r_valid_o  <= 1'b1;
            r_addr_o   <= i_r_addr_i;
            r_len_o    <= i_r_len_i;
            last_gnt_r <= SIDE_I;
            beat_cnt_r <= 8'd0;
          end else if (pick_d_s) begin
            state_r    <= GNT_D;
            r_valid_o  <= 1'b1;
            r_addr_o   <= d_r_addr_i;
            r_len_o    <= d_r_len_i;
            last_gnt_r <= SIDE_D;
            beat_cnt_r <= 8'd0;
          end else begin
            state_r   <= IDLE;
            r_valid_o <= 1'b0;
          end
        end
        GNT_I, GNT_D: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
          end
          // The AXI burst cannot be aborted, so only the last beat releases the grant.
          if (last_beat_s) begin
            state_r   <= IDLE;
            r_valid_o <= 1'b0;
            if (beat_cnt_r != r_len_o) begin
              err_o <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          r_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Strobe routing to the granted side; data is broadcast unqualified.
  always_comb begin
    i_r_ready_o = 1'b0;
    i_r_last_o  = 1'b0;
    d_r_ready_o = 1'b0;
    d_r_last_o  = 1'b0;
    r_data_o    = r_data_i;
    if (state_r == GNT_I) begin
      i_r_ready_o = r_ready_i;
      i_r_last_o  = r_ready_i & r_last_i;
    end else if (state_r == GNT_D) begin
      d_r_ready_o = r_ready_i;
      d_r_last_o  = r_ready_i & r_last_i;
    end else begin
      i_r_ready_o = 1'b0;
      d_r_ready_o = 1'b0;
    end
  end

`ifdef AXI_RD_ARB_PERF_EN
  // Wait counters: cycles a requester is valid but not the granted side, IDLE gaps included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_wait_cnt_o <= 64'd0;
      d_wait_cnt_o <= 64'd0;
    end else begin
      if (i_r_valid_i && (state_r != GNT_I)) begin
        i_wait_cnt_o <= i_wait_cnt_o + 64'd1;
      end
      if (d_r_valid_i && (state_r != GNT_D)) begin
        d_wait_cnt_o <= d_wait_cnt_o + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041412_axi_rd_arb.sv
// Self-checking bench for ysyx_22041412_axi_rd_arb: strobe table, directed corner sequences,
// and randomized bursts checked against a transaction-level arbitration model.
module tb_ysyx_22041412_axi_rd_arb;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_r_valid_i, d_r_valid_i;
  logic [AW-1:0] i_r_addr_i, d_r_addr_i;
  logic [7:0]    i_r_len_i, d_r_len_i;
  logic          i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o;
  logic [DW-1:0] r_data_o, r_data_i;
  logic          r_valid_o;
  logic [AW-1:0] r_addr_o;
  logic [7:0]    r_len_o;
  logic          r_ready_i, r_last_i;
  logic          err_o;
`ifdef AXI_RD_ARB_PERF_EN
  logic [63:0]   i_wait_cnt_o, d_wait_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041412_axi_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
`ifdef AXI_RD_ARB_PERF_EN
    .i_wait_cnt_o(i_wait_cnt_o),
    .d_wait_cnt_o(d_wait_cnt_o),
`endif
    .clk(clk), .rst_n(rst_n),
    .i_r_valid_i(i_r_valid_i), .i_r_addr_i(i_r_addr_i), .i_r_len_i(i_r_len_i),
    .i_r_ready_o(i_r_ready_o), .i_r_last_o(i_r_last_o),
    .d_r_valid_i(d_r_valid_i), .d_r_addr_i(d_r_addr_i), .d_r_len_i(d_r_len_i),
    .d_r_ready_o(d_r_ready_o), .d_r_last_o(d_r_last_o),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_addr_o(r_addr_o), .r_len_o(r_len_o),
    .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_data_i(r_data_i), .err_o(err_o)
  );

  typedef struct {
    int         side;   // 0 idle, 1 I granted, 2 D granted
    logic       rdy;
    logic       lst;
    logic [3:0] exp;    // {i_ready, i_last, d_ready, d_last}
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strb(input string nm, input int side, input logic rdy, input logic lst);
    logic [3:0] e;
    e = 4'b0000;
    if (side == 1) e = {rdy, rdy & lst, 2'b00};
    else if (side == 2) e = {2'b00, rdy, rdy & lst};
    chk(nm, {60'd0, i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o}, {60'd0, e});
  endtask

  task automatic apply_table(input int side);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].side == side) begin
        r_ready_i = tbl[i].rdy;
        r_last_i  = tbl[i].lst;
        #1;
        chk($sformatf("table_s%0d_%0d", side, i),
            {60'd0, i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o}, {60'd0, tbl[i].exp});
      end
    end
    r_ready_i = 1'b0;
    r_last_i  = 1'b0;
  endtask

  // Beats 0..last_idx back to back, last strobe on last_idx.
  task automatic burst(input int side, input int last_idx);
    for (int b = 0; b <= last_idx; b++) begin
      r_ready_i = 1'b1;
      r_last_i  = (b == last_idx);
      #1;
      chk_strb("burst_strb", side, 1'b1, r_last_i);
      step();
    end
    r_ready_i = 1'b0;
    r_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_r_valid_i = 1'b0; d_r_valid_i = 1'b0;
    r_ready_i = 1'b0; r_last_i = 1'b0;
    #2;
    chk("rst_valid", r_valid_o, 0);
    chk("rst_addr", r_addr_o, 0);
    chk("rst_len", r_len_o, 0);
    chk("rst_err", err_o, 0);
    chk_strb("rst_strb", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Random-phase model state
  logic          ip, dp, last_d, err_exp;
  int            w, k, sel, gaps, exp_len;
  logic [AW-1:0] exp_addr;

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{0, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{0, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{0, 1'b1, 1'b1, 4'b0000};
    tbl[4]  = '{1, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1, 1'b1, 1'b0, 4'b1000};
    tbl[6]  = '{1, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{1, 1'b1, 1'b1, 4'b1100};
    tbl[8]  = '{2, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{2, 1'b1, 1'b0, 4'b0010};
    tbl[10] = '{2, 1'b0, 1'b1, 4'b0000};
    tbl[11] = '{2, 1'b1, 1'b1, 4'b0011};

    i_r_addr_i = '0; d_r_addr_i = '0; i_r_len_i = 8'd0; d_r_len_i = 8'd0; r_data_i = '0;
    do_reset();
    apply_table(0);

    // 1: I only, len=3, four beats
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_1000; i_r_len_i = 8'd3;
    #1 chk("t1_valid_before", r_valid_o, 0);
    step();
    chk("t1_valid", r_valid_o, 1);
    chk("t1_addr", r_addr_o, 32'h0000_1000);
    chk("t1_len", r_len_o, 3);
    apply_table(1);
    burst(1, 3);
    i_r_valid_i = 1'b0;
    #1 chk("t1_idle", r_valid_o, 0);
    chk("t1_err", err_o, 0);
    step();

    // 2: both after reset -> D first, one IDLE cycle, then I
    do_reset();
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_2000; i_r_len_i = 8'd0;
    d_r_valid_i = 1'b1; d_r_addr_i = 32'h0000_3000; d_r_len_i = 8'd0;
    step();
    chk("t2_first_d", r_addr_o, 32'h0000_3000);
    burst(2, 0);
    d_r_valid_i = 1'b0;
    #1 chk("t2_gap", r_valid_o, 0);
    step();
    chk("t2_then_i_valid", r_valid_o, 1);
    chk("t2_then_i", r_addr_o, 32'h0000_2000);
    burst(1, 0);
    i_r_valid_i = 1'b0;
    step();

    // 3: D held across bursts, I joins mid-first -> D, I, D
    d_r_valid_i = 1'b1; d_r_addr_i = 32'h0000_4000; d_r_len_i = 8'd1;
    step();
    chk("t3_d1_addr", r_addr_o, 32'h0000_4000);
    apply_table(2);
    r_ready_i = 1'b1; r_last_i = 1'b0;
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_5000; i_r_len_i = 8'd0;
    #1 chk_strb("t3_beat0", 2, 1'b1, 1'b0);
    step();
    r_last_i = 1'b1;
    #1 chk_strb("t3_beat1", 2, 1'b1, 1'b1);
    step();
    r_ready_i = 1'b0; r_last_i = 1'b0;
    d_r_addr_i = 32'h0000_6000; d_r_len_i = 8'd2;
    #1 chk("t3_gap1", r_valid_o, 0);
    step();
    chk("t3_i_addr", r_addr_o, 32'h0000_5000);
    chk("t3_i_len", r_len_o, 0);
    burst(1, 0);
    i_r_valid_i = 1'b0;
    #1 chk("t3_gap2", r_valid_o, 0);
    step();
    chk("t3_d2_addr", r_addr_o, 32'h0000_6000);
    chk("t3_d2_len", r_len_o, 2);
    burst(2, 2);
    d_r_valid_i = 1'b0;
    step();

    // 4: short burst sets sticky err; IDLE strobes ignored
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_7000; i_r_len_i = 8'd3;
    step();
    burst(1, 1);
    i_r_valid_i = 1'b0;
    #1 chk("t4_idle", r_valid_o, 0);
    chk("t4_err", err_o, 1);
    r_ready_i = 1'b1; r_last_i = 1'b1;
    #1 chk_strb("t4_idle_strb", 0, 1'b1, 1'b1);
    step();
    r_ready_i = 1'b0; r_last_i = 1'b0;
    chk("t4_err_sticky", err_o, 1);
    chk("t4_still_idle", r_valid_o, 0);

    // 5: reset mid-burst of I, then D-only request
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_8000; i_r_len_i = 8'd3;
    step();
    chk("t5_granted", r_valid_o, 1);
    r_ready_i = 1'b1;
    #1 chk_strb("t5_pre_rst", 1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 chk("t5_rst_valid", r_valid_o, 0);
    chk_strb("t5_rst_strb", 0, 1'b1, 1'b0);
    chk("t5_rst_err", err_o, 0);
    r_ready_i = 1'b0; i_r_valid_i = 1'b0;
    d_r_valid_i = 1'b1; d_r_addr_i = 32'h0000_9000; d_r_len_i = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_d_valid", r_valid_o, 1);
    chk("t5_d_addr", r_addr_o, 32'h0000_9000);
    burst(2, 0);
    d_r_valid_i = 1'b0;
    step();

`ifdef AXI_RD_ARB_PERF_EN
    // 6: D waits through a 10-beat I burst plus the IDLE gap
    do_reset();
    i_r_valid_i = 1'b1; i_r_addr_i = 32'h0000_a000; i_r_len_i = 8'd9;
    step();
    d_r_valid_i = 1'b1; d_r_addr_i = 32'h0000_b000; d_r_len_i = 8'd0;
    burst(1, 9);
    i_r_valid_i = 1'b0;
    step();
    chk("t6_d_addr", r_addr_o, 32'h0000_b000);
    chk("t6_d_wait", d_wait_cnt_o, 11);
    chk("t6_i_wait", i_wait_cnt_o, 1);
    burst(2, 0);
    d_r_valid_i = 1'b0;
    step();
`endif

    // Randomized bursts against a transaction-level model
    do_reset();
    ip = 1'b0; dp = 1'b0; last_d = 1'b0; err_exp = 1'b0;
    for (int rd = 0; rd < 200; rd++) begin
      if (!ip && !dp) begin
        sel = $urandom_range(0, 2);
        if (sel != 1) begin ip = 1'b1; i_r_addr_i = $urandom; i_r_len_i = 8'($urandom_range(0, 5)); end
        if (sel != 0) begin dp = 1'b1; d_r_addr_i = $urandom; d_r_len_i = 8'($urandom_range(0, 5)); end
      end
      i_r_valid_i = ip; d_r_valid_i = dp;
      r_ready_i = 1'($urandom % 2); r_last_i = 1'($urandom % 2);
      #1 chk("rnd_idle_valid", r_valid_o, 0);
      chk_strb("rnd_idle_strb", 0, r_ready_i, r_last_i);
      chk("rnd_err", err_o, err_exp);
      w = (ip && dp) ? (last_d ? 1 : 2) : (ip ? 1 : 2);
      last_d = (w == 2);
      exp_addr = (w == 1) ? i_r_addr_i : d_r_addr_i;
      exp_len  = (w == 1) ? int'(i_r_len_i) : int'(d_r_len_i);
      step();
      r_ready_i = 1'b0; r_last_i = 1'b0;
      #1 chk("rnd_grant_valid", r_valid_o, 1);
      chk("rnd_grant_addr", r_addr_o, exp_addr);
      chk("rnd_grant_len", r_len_o, exp_len);
      k = ($urandom % 4 == 0) ? $urandom_range(0, exp_len + 1) : exp_len;
      for (int b = 0; b <= k; b++) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          if (w == 1 && !dp && ($urandom % 4 == 0)) begin
            dp = 1'b1; d_r_valid_i = 1'b1; d_r_addr_i = $urandom; d_r_len_i = 8'($urandom_range(0, 5));
          end else if (w == 2 && !ip && ($urandom % 4 == 0)) begin
            ip = 1'b1; i_r_valid_i = 1'b1; i_r_addr_i = $urandom; i_r_len_i = 8'($urandom_range(0, 5));
          end
          r_ready_i = 1'b0; r_last_i = 1'($urandom % 2);
          #1 chk_strb("rnd_gap_strb", w, 1'b0, r_last_i);
          step();
        end
        r_ready_i = 1'b1; r_last_i = (b == k); r_data_i = {$urandom, $urandom};
        #1 chk_strb("rnd_beat_strb", w, 1'b1, r_last_i);
        chk("rnd_data", r_data_o, r_data_i);
        step();
      end
      r_ready_i = 1'b0; r_last_i = 1'b0;
      if (k != exp_len) err_exp = 1'b1;
      if (w == 1) ip = 1'b0;
      else dp = 1'b0;
    end
    i_r_valid_i = 1'b0; d_r_valid_i = 1'b0;
    #1 chk("rnd_final_err", err_o, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
